// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared op encoding and limits for the pipelined multiplier
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_LO  = 2'd0,
        MUL_HSS = 2'd1,
        MUL_HSU = 2'd2,
        MUL_HUU = 2'd3
    } mul_op_t;

    localparam int MUL_MAX_LATENCY = 8;

    // rs1 is signed for MULH and MULHSU
    function automatic logic a_is_signed(input mul_op_t op);
        return (op == MUL_HSS) || (op == MUL_HSU);
    endfunction

    // rs2 is signed for MULH only
    function automatic logic b_is_signed(input mul_op_t op);
        return (op == MUL_HSS);
    endfunction

endpackage

// File: rtl/mul_core.sv
// rtl/mul_core.sv - operand extension and full-width product for the multiply group
module mul_core
    import mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  mul_op_t             op,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic [2*XLEN-1:0]   product
);

    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;

    // extending past XLEN+1 bits leaves the low 2*XLEN product bits unchanged
    always_comb begin
        a_ext   = {{XLEN{a_is_signed(op) & a[XLEN-1]}}, a};
        b_ext   = {{XLEN{b_is_signed(op) & b[XLEN-1]}}, b};
        product = a_ext * b_ext;
    end

endmodule

// File: rtl/mul_pipe.sv
// rtl/mul_pipe.sv - pipelined RV32M/RV64M multiplier with stall and flush control
module mul_pipe
    import mul_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LATENCY = 4,
    parameter int TAG_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  mul_op_t           in_op,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("mul_pipe: XLEN must be 32 or 64");
    end
    if (LATENCY < 0 || LATENCY > MUL_MAX_LATENCY) begin : g_bad_latency
        $error("mul_pipe: LATENCY out of range");
    end

    logic [2*XLEN-1:0] product;

    mul_core #(.XLEN(XLEN)) u_core (
        .op      (in_op),
        .a       (in_a),
        .b       (in_b),
        .product (product)
    );

    function automatic logic [XLEN-1:0] pick_half(input mul_op_t op, input logic [2*XLEN-1:0] p);
        return (op == MUL_LO) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    if (LATENCY == 0) begin : g_comb
        assign in_ready   = out_ready;
        assign out_valid  = in_valid & ~flush;
        assign out_result = pick_half(in_op, product);
        assign out_tag    = in_tag;
        assign busy       = 1'b0;
    end else begin : g_pipe
        logic [LATENCY-1:0]  vld;
        mul_op_t             op_q   [LATENCY];
        logic [2*XLEN-1:0]   prod_q [LATENCY];
        logic [TAG_W-1:0]    tag_q  [LATENCY];
        logic                adv;
        logic                accept;

        assign adv    = ~vld[LATENCY-1] | out_ready;
        assign accept = in_valid & adv & ~flush;

        // valid bits: reset or flush empties the pipe, otherwise shift on advance
        always_ff @(posedge clk) begin
            if (!reset_n || flush) begin
                vld <= '0;
            end else if (adv) begin
                vld[0] <= accept;
                for (int i = 1; i < LATENCY; i++) begin
                    vld[i] <= vld[i-1];
                end
            end
        end

        // payload moves in lockstep with the valid bits; empty slots carry don't-care data
        always_ff @(posedge clk) begin
            if (adv) begin
                op_q[0]   <= in_op;
                prod_q[0] <= product;
                tag_q[0]  <= in_tag;
                for (int i = 1; i < LATENCY; i++) begin
                    op_q[i]   <= op_q[i-1];
                    prod_q[i] <= prod_q[i-1];
                    tag_q[i]  <= tag_q[i-1];
                end
            end
        end

        assign in_ready   = adv;
        assign out_valid  = vld[LATENCY-1] & ~flush;
        assign out_result = pick_half(op_q[LATENCY-1], prod_q[LATENCY-1]);
        assign out_tag    = tag_q[LATENCY-1];
        assign busy       = |vld;
    end

endmodule

// File: tb/tb_mul_pipe.sv
// tb/tb_mul_pipe.sv - self-checking bench for mul_pipe
module tb_mul_pipe;
    import mul_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
    mul_op_t     in_op;
    logic [31:0] in_a, in_b, out_result;
    logic [4:0]  in_tag, out_tag;

    mul_pipe #(.XLEN(32), .LATENCY(4), .TAG_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .busy(busy)
    );

    logic        v64, ordy64, fl64;
    mul_op_t     op64;
    logic [63:0] a64, b64;
    logic [4:0]  tg64;
    logic        rdy64 [3];
    logic        ov64  [3];
    logic        bsy64 [3];
    logic [63:0] res64 [3];
    logic [4:0]  otg64 [3];

    for (genvar k = 0; k < 3; k++) begin : g64
        localparam int LAT = (k == 0) ? 0 : ((k == 1) ? 1 : 3);
        mul_pipe #(.XLEN(64), .LATENCY(LAT), .TAG_W(5)) u_dut (
            .clk(clk), .reset_n(reset_n), .in_valid(v64), .in_ready(rdy64[k]),
            .in_op(op64), .in_a(a64), .in_b(b64), .in_tag(tg64), .flush(fl64),
            .out_valid(ov64[k]), .out_ready(ordy64), .out_result(res64[k]),
            .out_tag(otg64[k]), .busy(bsy64[k])
        );
    end

    int total = 0;
    int bad   = 0;

    typedef struct { mul_op_t op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;
    vec_t vec [8];

    typedef struct { logic [63:0] res; logic [4:0] tag; } exp_t;
    exp_t sb [3][1024];
    int   wr [3];
    int   rd [3];

    int issued, retired, stall;
    bit stalled;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference: true signed/unsigned integer product, then pick the requested half
    function automatic logic [63:0] ref_mul(input mul_op_t op, input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] va, vb, p;
        if (op == MUL_HSS || op == MUL_HSU) va = 130'($signed(a));
        else                                va = $signed({66'b0, a});
        if (op == MUL_HSS) vb = 130'($signed(b));
        else               vb = $signed({66'b0, b});
        p = va * vb;
        return (op == MUL_LO) ? p[63:0] : p[127:64];
    endfunction

    function automatic logic [31:0] bp_exp(input int j);
        logic [31:0] x, y;
        x = 32'(j * 7 + 3);
        y = 32'hDEAD0000 + 32'(j);
        return x * y;
    endfunction

    function automatic logic [31:0] huu32(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] t;
        t = {32'b0, x} * {32'b0, y};
        return t[63:32];
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic sample64();
        for (int k = 0; k < 3; k++) begin
            if (v64 && rdy64[k]) begin
                sb[k][wr[k]].res = ref_mul(op64, a64, b64);
                sb[k][wr[k]].tag = tg64;
                wr[k]++;
            end
            if (ov64[k] && ordy64) begin
                if (rd[k] == wr[k]) begin
                    check("rand_spurious_valid", 64'(ov64[k]), 64'(0));
                end else begin
                    check("rand_result", res64[k], sb[k][rd[k]].res);
                    check("rand_tag", 64'(otg64[k]), 64'(sb[k][rd[k]].tag));
                    rd[k]++;
                end
            end
        end
    endtask

    initial begin
        vec[0] = '{MUL_LO,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vec[1] = '{MUL_HSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vec[2] = '{MUL_HSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vec[3] = '{MUL_HUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vec[4] = '{MUL_HSS, 32'h80000000, 32'h80000000, 32'h40000000};
        vec[5] = '{MUL_HUU, 32'h80000000, 32'h80000000, 32'h40000000};
        vec[6] = '{MUL_HSU, 32'h80000000, 32'h80000000, 32'hC0000000};
        vec[7] = '{MUL_LO,  32'h80000000, 32'h80000000, 32'h00000000};

        for (int k = 0; k < 3; k++) begin
            wr[k] = 0;
            rd[k] = 0;
        end

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = MUL_LO;
        in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        v64 = 1'b0; ordy64 = 1'b1; fl64 = 1'b0; op64 = MUL_LO; a64 = '0; b64 = '0; tg64 = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));

        // back-to-back table vectors, results four cycles behind issue
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c < 8) begin
                in_valid = 1'b1; in_op = vec[c].op; in_a = vec[c].a; in_b = vec[c].b; in_tag = 5'(c);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 4 && c < 12) begin
                check("vec_valid", 64'(out_valid), 64'(1));
                check("vec_result", 64'(out_result), 64'(vec[c-4].exp));
                check("vec_tag", 64'(out_tag), 64'(c - 4));
            end else begin
                check("vec_idle", 64'(out_valid), 64'(0));
            end
        end

        // backpressure: three-cycle stall once the first result shows up
        issued = 0; retired = 0; stall = 0; stalled = 1'b0;
        for (int c = 0; c < 60 && retired < 8; c++) begin
            @(negedge clk);
            if (!stalled && out_valid) begin
                stalled = 1'b1;
                stall = 3;
            end
            out_ready = (stall == 0);
            if (stall > 0) stall--;
            in_valid = (issued < 8);
            in_op = MUL_LO;
            in_tag = 5'(issued + 1);
            in_a = 32'(issued * 7 + 3);
            in_b = 32'hDEAD0000 + 32'(issued);
            #1;
            if (!out_ready) check("bp_in_ready", 64'(in_ready), 64'(0));
            if (out_valid && out_ready) begin
                check("bp_tag", 64'(out_tag), 64'(retired + 1));
                check("bp_result", 64'(out_result), 64'(bp_exp(retired)));
                retired++;
            end
            if (in_valid && in_ready) issued++;
        end
        check("bp_retired", 64'(retired), 64'(8));
        in_valid = 1'b0;
        out_ready = 1'b1;

        // flush kills three in-flight ops and the op offered alongside it
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            flush = (c == 4);
            in_valid = (c < 3) || (c == 4) || (c == 6);
            in_op = MUL_HUU;
            in_a = 32'hF0000000 + 32'(c);
            in_b = 32'h12345678;
            in_tag = 5'(10 + c);
            #1;
            if (c == 5) check("flush_busy", 64'(busy), 64'(0));
            if (c == 10) begin
                check("flush_after_valid", 64'(out_valid), 64'(1));
                check("flush_after_result", 64'(out_result), 64'(huu32(32'hF0000006, 32'h12345678)));
                check("flush_after_tag", 64'(out_tag), 64'(16));
            end else begin
                check("flush_no_valid", 64'(out_valid), 64'(0));
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;

        // reset with a full, stalled pipe
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            out_ready = (c >= 5);
            reset_n = (c != 4);
            in_valid = (c < 4);
            in_op = MUL_LO; in_a = 32'(c + 1); in_b = 32'h3; in_tag = 5'(c);
            #1;
            if (c == 4) check("rst_full_busy", 64'(busy), 64'(1));
            if (c == 5) check("rst_busy", 64'(busy), 64'(0));
            if (c >= 5) check("rst_no_valid", 64'(out_valid), 64'(0));
        end
        reset_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;

        // random regression on the 64-bit instances
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            v64 = ($urandom_range(0, 3) != 0);
            ordy64 = ($urandom_range(0, 3) != 0);
            op64 = mul_op_t'($urandom_range(0, 3));
            a64 = pick_operand();
            b64 = pick_operand();
            tg64 = 5'($urandom);
            #1;
            sample64();
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            v64 = 1'b0;
            ordy64 = 1'b1;
            #1;
            sample64();
        end
        for (int k = 0; k < 3; k++) begin
            check("rand_drained", 64'(rd[k]), 64'(wr[k]));
            check("rand_busy_idle", 64'(bsy64[k]), 64'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
